// File: rtl/packet_queue_pkg.sv
// Shared widths and packet types for the receive-path packet queue.
// Flit geometry mirrors the NIC-wide flit width and maximum packet length.
package packet_queue_pkg;

  localparam int FLIT_WIDTH        = 32;
  localparam int MAX_PACKET_LENGHT = 4;
  localparam int LINK_W            = FLIT_WIDTH * MAX_PACKET_LENGHT;

  typedef logic [LINK_W-1:0]            link_t;
  typedef logic [MAX_PACKET_LENGHT-1:0] sel_t;

endpackage

// File: rtl/packet_queue_ctrl.sv
// Pointers, occupancy counter and both request/grant handshakes of the packet queue.
// Grant is combinational from registered count and request; count updates one edge later.
module packet_queue_ctrl #(
  parameter int N_PACKETS      = 4,
  parameter int N_BITS_POINTER = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_req_i,
  input  logic                      pop_req_i,
  output logic                      push_o,
  output logic                      empty_o,
  output logic [N_BITS_POINTER-1:0] wr_ptr_o,
  output logic [N_BITS_POINTER-1:0] rd_ptr_o,
  output logic [N_BITS_POINTER:0]   cnt_o
);

  localparam int CNT_W = N_BITS_POINTER + 1;

  logic [N_BITS_POINTER-1:0] wr_ptr_q, wr_ptr_d;
  logic [N_BITS_POINTER-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      full, empty, pop;

  assign full  = (cnt_q == CNT_W'(N_PACKETS));
  assign empty = (cnt_q == '0);
  // Gate with reset so the grant is low while reset is held, even though cnt is 0.
  assign push_o  = push_req_i && !full && rst;
  assign pop     = pop_req_i && !empty;
  assign empty_o = empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_o) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_o && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push_o) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/packet_queue.sv
// Whole-packet FIFO between the flits buffer and message assembly; push grant is same-cycle.
// Data visible one edge after push; full queue withholds grant, empty queue drives zeros.
module packet_queue
  import packet_queue_pkg::*;
#(
  parameter int N_PACKETS      = 4,
  parameter int N_BITS_POINTER = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    r_pkt_to_msg_i,
  output logic                    g_pkt_to_msg_o,
  input  link_t                   in_link_i,
  input  sel_t                    in_sel_i,
  output logic                    r_msg_o,
  input  logic                    g_msg_i,
  output link_t                   out_link_o,
  output sel_t                    out_sel_o,
  output logic [N_BITS_POINTER:0] count_o
);

  link_t                     link_q [N_PACKETS];
  sel_t                      sel_q  [N_PACKETS];
  logic                      push, empty;
  logic [N_BITS_POINTER-1:0] wr_ptr, rd_ptr;

  packet_queue_ctrl #(
    .N_PACKETS      (N_PACKETS),
    .N_BITS_POINTER (N_BITS_POINTER)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (r_pkt_to_msg_i),
    .pop_req_i  (g_msg_i),
    .push_o     (push),
    .empty_o    (empty),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .cnt_o      (count_o)
  );

  assign g_pkt_to_msg_o = push;
  assign r_msg_o        = !empty;

  // Payload needs no reset: it is only ever observed through the empty-gated mux.
  always_ff @(posedge clk) begin
    if (push) link_q[wr_ptr] <= in_link_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PACKETS; i++) sel_q[i] <= '0;
    end else if (push) begin
      sel_q[wr_ptr] <= in_sel_i;
    end
  end

  assign out_link_o = empty ? '0 : link_q[rd_ptr];
  assign out_sel_o  = empty ? '0 : sel_q[rd_ptr];

endmodule

// File: doc/packet_queue.md
# packet_queue

Packet FIFO sitting directly downstream of the flits buffer in the NIC receive path. It accepts a complete packet (all flits plus the flit-valid mask) in one cycle through the request/grant handshake. It stores up to N_PACKETS packets and presents the oldest one, whole, to the message-assembly stage on the WISHBONE side through a second request/grant handshake. It decouples NoC packet arrival from WISHBONE consumption, so the flits buffer can return to IDLE and keep freeing credits while the bus side is busy.

## Interface

Parameters:
- N_PACKETS, 4: queue depth in packets; must be a power of two, at least 2.
- N_BITS_POINTER, 2: log2(N_PACKETS); read/write pointer width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- r_pkt_to_msg_i  in  1  upstream request: a complete packet is present on in_link_i/in_sel_i.
- g_pkt_to_msg_o  out  1  upstream grant; the packet is captured on this edge.
- in_link_i  in  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit i is at bits [i*`FLIT_WIDTH +: `FLIT_WIDTH], and flit 0 is the head or head_tail.
- in_sel_i  in  `MAX_PACKET_LENGHT  flit-valid mask; bit i high means flit i is valid.
- r_msg_o  out  1  downstream request: the queue is non-empty.
- g_msg_i  in  1  downstream grant; pops the head entry.
- out_link_o  out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  head-entry packet, same layout as in_link_i.
- out_sel_o  out  `MAX_PACKET_LENGHT  head-entry flit mask.
- count_o  out  N_BITS_POINTER+1  number of stored packets, 0..N_PACKETS.

## Operation

- Storage: an array of N_PACKETS entries, each holding {sel, link}. There is a write pointer wr_ptr, a read pointer rd_ptr and an occupancy counter cnt.
- Flags: full = (cnt == N_PACKETS); empty = (cnt == 0).
- Push:
  - g_pkt_to_msg_o = r_pkt_to_msg_i && !full, purely combinational.
  - When granted, the entry at wr_ptr is written with in_link_i/in_sel_i, and wr_ptr increments modulo N_PACKETS (natural wrap).
  - Upstream drops its request the cycle after the grant, so each grant corresponds to exactly one push.
- Pop:
  - r_msg_o = !empty.
  - pop = g_msg_i && !empty; rd_ptr increments modulo N_PACKETS.
  - g_msg_i while empty is ignored: no pointer or count change.
- Output data:
  - out_link_o and out_sel_o show the rd_ptr entry when non-empty.
  - Both are forced to 0 when empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, with both pointers advancing.
- Full: no grant is issued, even when g_msg_i is high that cycle; a full queue does not write through.
- Empty plus push: the packet becomes visible on out_* the next cycle; there is no same-cycle bypass.
- A packet with in_sel_i == 0 is still queued (no filtering in this stage).
- Reset (asynchronous, any time, including during a handshake):
  - wr_ptr, rd_ptr, cnt and all stored sel fields are cleared.
  - Link storage is not reset.
  - Any packet being granted in the reset cycle is lost.
- Output values during reset: g_pkt_to_msg_o 0 (forced low while rst is low), r_msg_o 0, out_link_o 0, out_sel_o 0, count_o 0.

## Timing

- Push latency: a request seen at edge N with not-full is granted in cycle N (combinational). Data is stored and count_o updated at edge N+1, and r_msg_o is high from N+1.
- Pop latency: a grant in cycle N gives the next entry, or zeros if now empty, on out_* after edge N+1.
- The grant depends only on the registered cnt and r_pkt_to_msg_i; there is no path from g_msg_i to g_pkt_to_msg_o.
- Sustained throughput: one push and one pop per cycle when neither full nor empty.

## Structure

- Widths and flit layout come from NIC-defines.v (`FLIT_WIDTH, `MAX_PACKET_LENGHT); no new global defines are needed.
- One sub-module is natural: packet_queue_ctrl, which holds the pointers, counter, full/empty flags and handshake logic. The top level holds the storage array and output muxing.

## Test plan

- Reset, then idle → r_msg_o=0, count_o=0, out_sel_o=0, out_link_o=0; g_msg_i=1 while empty changes nothing.
- Single head_tail packet with in_sel_i=0001 and flit0=0xA5 (low byte): grant in the request cycle; next cycle r_msg_o=1, out_sel_o=0001, count_o=1. Then g_msg_i for 1 cycle → count_o=0, outputs 0.
- Push 4 packets (N_PACKETS=4) with sel 0001, 0011, 0111, 1111 and no pops → count_o=4. A fifth request is held with g_pkt_to_msg_o=0 until one g_msg_i pulse, then granted the following cycle.
- Full queue with request and g_msg_i in the same cycle → pop only, count_o 4→3, and the grant comes the next cycle.
- Simultaneous push/pop at count 2 for 10 cycles → count_o stays 2, pointers wrap, and packets leave in order (check tag values 1..12).
- Assert rst low mid-handshake, with count_o=3 and an active request → all outputs are 0 immediately; after release the queue is empty and the first new packet pops correctly.
